// File: rtl/serial_difference_ctrl.sv
// serial_difference_ctrl: bit-serial x - y sequencer driving one full-difference cell LSB first
module serial_difference_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH:0]   diferenca
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state, w_next;
  logic [WIDTH-1:0] r_xs, r_ys, r_tb, w_tb, w_tdn;
  logic [WIDTH-2:0] r_td;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, w_a, w_b, w_d, w_bout, w_acc, w_last;
  assign w_a    = r_xs[0];
  assign w_b    = r_ys[0];
  assign w_d    = w_a ^ w_b ^ r_bin;
  assign w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & r_bin);
  assign w_acc  = (r_state == S_IDLE || r_state == S_DONE) && start;
  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_tdn  = {w_d, r_td};
  always_comb begin
    w_tb        = r_tb;
    w_tb[r_cnt] = w_bout;
  end
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  always_comb
    w_next = w_acc ? S_RUN : (r_state == S_RUN) ? (w_last ? S_DONE : S_RUN) : S_IDLE;
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end
  // Results move only on the completion edge, so an aborted run leaves them cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xs      <= '0;
      r_ys      <= '0;
      r_td      <= '0;
      r_tb      <= '0;
      r_cnt     <= '0;
      r_bin     <= 1'b0;
      borrow    <= '0;
      diferenca <= '0;
    end else if (w_acc) begin
      r_xs  <= x;
      r_ys  <= y;
      r_td  <= '0;
      r_tb  <= '0;
      r_cnt <= '0;
      r_bin <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_td  <= w_tdn[WIDTH-1:1];
      r_tb  <= w_tb;
      r_bin <= w_bout;
      r_xs  <= r_xs >> 1;
      r_ys  <= r_ys >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        diferenca <= {w_bout, w_tdn};
        borrow    <= w_tb;
      end
    end
  end
endmodule

// File: tb/tb_serial_difference_ctrl.sv
// tb_serial_difference_ctrl: randomized and directed checks against an arithmetic reference model
module tb_serial_difference_ctrl;
  localparam int W = 5;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic         busy, done;
  logic [W-1:0] borrow;
  logic [W:0]   diferenca;
  int           n_chk = 0, n_err = 0;
  logic [W:0]   exp_d = '0;
  logic [W-1:0] exp_b = '0;

  serial_difference_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .borrow(borrow), .diferenca(diferenca)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Borrow out of bit i is set exactly when the low i+1 bits of a are smaller than those of b.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi, m;
    ai = int'(a);
    bi = int'(b);
    exp_d = {1'b0, a} - {1'b0, b};
    for (int i = 0; i < W; i++) begin
      m = 1 << (i + 1);
      exp_b[i] = (ai % m) < (bi % m);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit perturb);
    logic [W:0]   pd;
    logic [W-1:0] pb;
    int n, nb;
    pd = exp_d;
    pb = exp_b;
    n  = 0;
    nb = 0;
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model(a, b);
    while (!done && n < 20) begin
      if (busy) nb++;
      if (n == 2) begin
        chk("hold_d", 32'(diferenca), 32'(pd));
        chk("hold_b", 32'(borrow), 32'(pb));
      end
      if (perturb && n < 3) begin
        x = W'($urandom); y = W'($urandom); start = 1'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 5);
    chk("busy_cycles", nb, 5);
    chk("busy_at_done", 32'(busy), 0);
    chk("diff", 32'(diferenca), 32'(exp_d));
    chk("borrow", 32'(borrow), 32'(exp_b));
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diferenca), 0);
    chk("rst_borrow", 32'(borrow), 0);

    do_op(5'b01011, 5'b00111, 0);
    chk("tp1_lit_d", 32'(diferenca), 32'(6'b000100));
    chk("tp1_lit_b", 32'(borrow), 32'(5'b00100));
    do_op(5'b11001, 5'b01101, 0);
    chk("tp2_lit_d", 32'(diferenca), 32'(6'b001100));
    chk("tp2_lit_b", 32'(borrow), 32'(5'b01100));
    do_op(5'b00001, 5'b00001, 0);
    chk("tp3_lit_d", 32'(diferenca), 0);
    do_op(5'b01000, 5'b10101, 0);
    chk("tp4_lit_d", 32'(diferenca), 32'(6'b110011));
    chk("tp4_lit_b", 32'(borrow), 32'(5'b10111));
    do_op(5'b00000, 5'b01011, 0);
    chk("tp5_lit_d", 32'(diferenca), 32'(6'b110101));
    chk("tp5_lit_b", 32'(borrow), 32'(5'b11111));

    // back-to-back: start held through DONE
    @(negedge clk);
    x = 5'b01011; y = 5'b00111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("b2b_first_lat", n, 5);
    chk("b2b_first_d", 32'(diferenca), 32'(6'b000100));
    x = 5'b11001; y = 5'b01101; start = 1'b1;
    n = 0;
    while (n == 0 || (!done && n < 20)) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) chk("b2b_no_idle", 32'(busy), 1);
      if (n == 3) chk("b2b_hold_d", 32'(diferenca), 32'(6'b000100));
    end
    chk("b2b_spacing", n, 6);
    chk("b2b_second_d", 32'(diferenca), 32'(6'b001100));
    chk("b2b_second_b", 32'(borrow), 32'(5'b01100));
    model(5'b11001, 5'b01101);
    @(negedge clk);

    do_op(5'b01011, 5'b00111, 1);
    chk("perturb_lit_d", 32'(diferenca), 32'(6'b000100));

    // reset mid-run at bit 3
    @(negedge clk);
    x = 5'b01000; y = 5'b10101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(diferenca), 0);
    chk("abort_borrow", 32'(borrow), 0);
    exp_d = '0;
    exp_b = '0;
    do_op(5'b01011, 5'b00111, 0);
    chk("post_abort_d", 32'(diferenca), 32'(6'b000100));

    for (int i = 0; i < 40; i++) do_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/serial_difference_ctrl.md
Name: serial_difference_ctrl

Overview:
- Bit-serial subtraction sequencer. Computes x - y over WIDTH clock cycles by driving a single full-difference cell (a, b, borrow-in → difference, borrow-out) LSB first.
- Replaces the WIDTH-cell ripple subtractor chain where area matters.
- Produces the same WIDTH+1-bit result and the same per-bit borrow vector as the ripple version.
- Sits between a requester (start/done handshake) and the ALU result bus.

Parameters:
- WIDTH, 5, operand width in bits (≥ 2); result is WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  minuend; captured on the accepted start edge.
- y  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle (DONE state).
- borrow  output  WIDTH  per-bit borrow-out vector of the last completed operation; bit i = borrow out of bit i.
- diferenca  output  WIDTH+1  last completed result; bits [WIDTH-1:0] = (x - y) mod 2^WIDTH, bit WIDTH = final borrow.

Behaviour:
- Reset: when reset = 1 at an edge, state goes to IDLE. The following are all cleared to 0: busy, done, borrow, diferenca, the internal shift registers, the bit counter and the borrow flip-flop. Reset has priority over every other input, including mid-RUN. An aborted operation leaves no partial result.
- States: IDLE, RUN, DONE. Binary-encoded, 2 bits.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at edge E0: load xs ← x, ys ← y, borrow flip-flop bin ← 0, count ← 0, temporary borrow vector ← 0, then go to RUN.
- RUN (busy = 1), one bit per edge:
  - a = xs[0], b = ys[0].
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin). This is identical to two cascaded half-difference stages OR-ed.
  - On each edge: shift d into the temporary result from the MSB side (right shift). Store bout into temporary borrow bit [count]. Set bin ← bout. Shift xs and ys right by 1. count ← count + 1.
  - The edge that processes count = WIDTH-1 goes to DONE. That same edge transfers the temporary result to diferenca[WIDTH-1:0], sets diferenca[WIDTH] ← bout, and transfers the temporary borrow vector (including this bit) to borrow.
  - start is ignored in RUN.
- DONE:
  - done = 1, busy = 0, for one cycle.
  - At the next edge: if start = 1, behave as an IDLE accept (back-to-back operation, go to RUN); otherwise go to IDLE.
- Latency: start accepted at edge E0 → bits processed at edges E1..E_WIDTH → done = 1 in the cycle after E_WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Result stability: diferenca and borrow change only at the completion edge or on reset. They hold their value in IDLE, throughout a subsequent RUN, and until the next completion.
- Arithmetic: x and y are unsigned WIDTH-bit. diferenca is a two's-complement WIDTH+1-bit value of x - y (sign = final borrow), exact for all inputs.
- Counter width: enough to hold WIDTH-1. No wrap beyond WIDTH-1 is reachable.
- x and y changing during RUN has no effect, since operands are captured.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then x = 01011, y = 00111, start for one cycle → busy high for 5 cycles; done pulses in cycle 6; diferenca = 000100, borrow = 00100.
- x = 11001, y = 01101 → diferenca = 001100, borrow = 01100. Then x = 00001, y = 00001 → diferenca = 000000, borrow = 00000.
- x = 01000, y = 10101 → diferenca = 110011, borrow = 10111. Then x = 00000, y = 01011 → diferenca = 110101, borrow = 11111.
- Back-to-back: hold start = 1 through DONE with new operands 11001/01101 → no IDLE cycle between operations; second done exactly 6 cycles after the first; diferenca stays 000100 until the second completion, then becomes 001100.
- Start pulses and x/y changes during RUN (cycles 2–4) → ignored; result equals the value from the originally captured operands; done count = 1.
- Assert reset at RUN bit 3 of 01000 − 10101 → next cycle busy = 0, done = 0, diferenca = 000000, borrow = 00000. A subsequent start with 01011/00111 yields 000100 with normal latency.
